// File: rtl/opfetch_pkg.sv
// Shared widths and state encoding for the operand fetch stage.
package opfetch_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RS1,
    S_RS2,
    S_DONE
  } state_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, x0 never busy.
module reg_scoreboard
#(
  parameter int unsigned ADDR_W = opfetch_pkg::ADDR_W
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_idx_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_idx_i,
  input  logic [ADDR_W-1:0] rs1_idx_i,
  input  logic [ADDR_W-1:0] rs2_idx_i,
  input  logic [ADDR_W-1:0] rd_idx_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              rd_busy_o
);
  import opfetch_pkg::*;

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q, busy_d;

  // Clear is applied before set so a same-cycle set on the same bit wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign rs1_busy_o = busy_q[rs1_idx_i];
  assign rs2_busy_o = busy_q[rs2_idx_i];
  assign rd_busy_o  = busy_q[rd_idx_i];
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: hazard check, shared-port register reads, valid/ready hand-off to execute.
module operand_fetch
#(
  parameter int unsigned XLEN   = opfetch_pkg::XLEN,
  parameter int unsigned ADDR_W = opfetch_pkg::ADDR_W
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [ADDR_W-1:0] dec_rs1,
  input  logic [ADDR_W-1:0] dec_rs2,
  input  logic              dec_use_rs2,
  input  logic [ADDR_W-1:0] dec_rd,
  input  logic              dec_wr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [ADDR_W-1:0] rf_index,
  output logic              rf_read_en,
  output logic              rf_write_en,
  output logic [XLEN-1:0]   rf_wdata,
  input  logic [XLEN-1:0]   rf_rdata,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_wr
);
  import opfetch_pkg::*;

  state_t            state_q;
  logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic              use_rs2_q, wr_q;
  logic              cap1_q, cap2_q;
  logic [XLEN-1:0]   op1_q, op2_q;

  logic rs1_haz, rs2_haz, rd_haz;
  logic wb_hit, rs1_stall, rs2_stall;
  logic rd1_go, rd2_go, hs, set_en;

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .set_en_i   (set_en),
    .set_idx_i  (rd_q),
    .clr_en_i   (wb_hit),
    .clr_idx_i  (wb_rd),
    .rs1_idx_i  (rs1_q),
    .rs2_idx_i  (rs2_q),
    .rd_idx_i   (rd_q),
    .rs1_busy_o (rs1_haz),
    .rs2_busy_o (rs2_haz),
    .rd_busy_o  (rd_haz)
  );

  // Writeback owns the shared port; any read wanted in the same cycle waits.
  always_comb begin
    wb_hit    = wb_valid && (wb_rd != '0) && !reset;
    rs1_stall = rs1_haz || (wr_q && rd_haz) || wb_valid;
    rs2_stall = rs2_haz || wb_valid;
    rd1_go    = (state_q == S_RS1) && !rs1_stall && (rs1_q != '0) && !reset;
    rd2_go    = (state_q == S_RS2) && use_rs2_q && !rs2_stall && (rs2_q != '0) && !reset;

    rf_write_en = wb_hit;
    rf_read_en  = rd1_go || rd2_go;
    rf_wdata    = wb_hit ? wb_data : '0;
    rf_index    = '0;
    if (wb_hit)      rf_index = wb_rd;
    else if (rd1_go) rf_index = rs1_q;
    else if (rd2_go) rf_index = rs2_q;

    dec_ready = (state_q == S_IDLE);
    ex_valid  = (state_q == S_DONE) && !cap2_q;
    hs        = ex_valid && ex_ready;
    set_en    = hs && wr_q && (rd_q != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      use_rs2_q <= 1'b0;
      wr_q      <= 1'b0;
      cap1_q    <= 1'b0;
      cap2_q    <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dec_valid) begin
            rs1_q     <= dec_rs1;
            rs2_q     <= dec_rs2;
            use_rs2_q <= dec_use_rs2;
            rd_q      <= dec_rd;
            wr_q      <= dec_wr;
            state_q   <= S_RS1;
          end
        end
        S_RS1: begin
          if (!rs1_stall) begin
            if (rs1_q == '0) op1_q  <= '0;
            else             cap1_q <= 1'b1;
            state_q <= S_RS2;
          end
        end
        S_RS2: begin
          // rs1 data is only present in the first S_RS2 cycle, so capture it even when stalled.
          if (cap1_q) begin
            op1_q  <= rf_rdata;
            cap1_q <= 1'b0;
          end
          if (!use_rs2_q) begin
            op2_q   <= '0;
            state_q <= S_DONE;
          end else if (!rs2_stall) begin
            if (rs2_q == '0) op2_q  <= '0;
            else             cap2_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (cap2_q) begin
            op2_q  <= rf_rdata;
            cap2_q <= 1'b0;
          end else if (ex_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ex_op1 = op1_q;
  assign ex_op2 = op2_q;
  assign ex_rd  = rd_q;
  assign ex_wr  = wr_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file on the shared port.
module tb_operand_fetch;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              dec_valid, dec_ready, dec_use_rs2, dec_wr;
  logic [ADDR_W-1:0] dec_rs1, dec_rs2, dec_rd;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic [ADDR_W-1:0] rf_index;
  logic              rf_read_en, rf_write_en;
  logic [XLEN-1:0]   rf_wdata, rf_rdata;
  logic              ex_valid, ex_ready, ex_wr;
  logic [XLEN-1:0]   ex_op1, ex_op2;
  logic [ADDR_W-1:0] ex_rd;

  int errors = 0;
  int checks = 0;
  int rd_pulses = 0;
  int n;
  int snap;

  logic [XLEN-1:0] rf_mem [32];

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_wr(dec_wr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_index(rf_index), .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd), .ex_wr(ex_wr)
  );

  // Register file: registered read, data valid the cycle after rf_read_en.
  always @(posedge clk) begin
    if (rf_write_en) rf_mem[rf_index] <= rf_wdata;
    if (rf_read_en)  rf_rdata <= rf_mem[rf_index];
  end

  always @(posedge clk) if (rf_read_en) rd_pulses <= rd_pulses + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Steps negedges after a dispatch; returns the first step index with ex_valid, or -1.
  task automatic wait_ex(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (i == 1) dec_valid = 1'b0;
      #1;
      if (ex_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic dispatch(input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                          input logic [4:0] rd, input logic wr);
    @(negedge clk);
    dec_valid = 1'b1; dec_rs1 = rs1; dec_rs2 = rs2; dec_use_rs2 = use2;
    dec_rd = rd; dec_wr = wr;
    #1;
    chk("dec_ready_at_dispatch", 32'(dec_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_use_rs2 = 1'b0;
    dec_rd = '0; dec_wr = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;

    // Reset, with a writeback attempted during reset that must be ignored
    @(negedge clk);
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD0003;
    #1;
    chk("wb_during_reset", 32'(rf_write_en), 32'd0);
    @(negedge clk);
    reset = 1'b0; wb_valid = 1'b0;
    #1;
    chk("rst_dec_ready", 32'(dec_ready), 32'd1);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_rf_read_en", 32'(rf_read_en), 32'd0);
    chk("rst_rf_write_en", 32'(rf_write_en), 32'd0);
    chk("rst_busy", dut.u_sb.busy_q, 32'h0);
    chk("rst_ex_op1", ex_op1, 32'h0);

    // Writebacks, including the x0 no-op
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h11111111;
    #1;
    chk("wb_x0_no_write", 32'(rf_write_en), 32'd0);
    @(negedge clk);
    wb_rd = 5'd5; wb_data = 32'hA5A50001;
    #1;
    chk("wb5_write_en", 32'(rf_write_en), 32'd1);
    chk("wb5_index", 32'(rf_index), 32'd5);
    chk("wb5_wdata", rf_wdata, 32'hA5A50001);
    @(negedge clk);
    wb_rd = 5'd6; wb_data = 32'h000000FF;
    @(negedge clk);
    wb_valid = 1'b0;

    // Two-read dispatch
    dispatch(5'd5, 5'd6, 1'b1, 5'd7, 1'b1);
    wait_ex(20, n);
    chk("lat_two_reads", 32'(n), 32'd4);
    chk("op1_x5", ex_op1, 32'hA5A50001);
    chk("op2_x6", ex_op2, 32'h000000FF);
    chk("ex_rd_7", 32'(ex_rd), 32'd7);
    chk("ex_wr_1", 32'(ex_wr), 32'd1);
    @(negedge clk);
    #1;
    chk("busy7_set", dut.u_sb.busy_q, 32'h00000080);
    chk("idle_after_hs", 32'(dec_ready), 32'd1);

    // RAW on x7: held in S_RS1 until the writeback clears it
    dispatch(5'd7, 5'd0, 1'b0, 5'd8, 1'b1);
    @(negedge clk);
    dec_valid = 1'b0;
    #1;
    chk("raw_no_read_a", 32'(rf_read_en), 32'd0);
    @(negedge clk);
    #1;
    chk("raw_no_read_b", 32'(rf_read_en), 32'd0);
    chk("raw_dec_ready", 32'(dec_ready), 32'd0);
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h00001234;
    #1;
    chk("raw_wb_write", 32'(rf_write_en), 32'd1);
    chk("raw_wb_defers_read", 32'(rf_read_en), 32'd0);
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    chk("raw_read_issues", 32'(rf_read_en), 32'd1);
    chk("raw_read_index", 32'(rf_index), 32'd7);
    wait_ex(20, n);
    chk("raw_lat_after_read", 32'(n), 32'd2);
    chk("raw_op1", ex_op1, 32'h00001234);
    chk("raw_op2", ex_op2, 32'h0);
    @(negedge clk);
    #1;
    chk("raw_busy", dut.u_sb.busy_q, 32'h00000100);

    // Port conflict: three writeback cycles while in S_RS1
    dispatch(5'd5, 5'd6, 1'b1, 5'd9, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      dec_valid = 1'b0;
      wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 32'h0BAD0008 + 32'(k);
      #1;
      chk("pc_read_blocked", 32'(rf_read_en), 32'd0);
      chk("pc_write_en", 32'(rf_write_en), 32'd1);
    end
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    chk("pc_read_issues", 32'(rf_read_en), 32'd1);
    chk("pc_read_index", 32'(rf_index), 32'd5);
    wait_ex(20, n);
    chk("pc_lat_plus3", 32'(n + 4), 32'd7);
    chk("pc_op1", ex_op1, 32'hA5A50001);
    chk("pc_op2", ex_op2, 32'h000000FF);
    @(negedge clk);
    #1;
    chk("pc_busy", dut.u_sb.busy_q, 32'h00000200);

    // x0 source, no rs2, no write
    snap = rd_pulses;
    dispatch(5'd0, 5'd6, 1'b0, 5'd3, 1'b0);
    wait_ex(20, n);
    chk("x0_lat", 32'(n), 32'd3);
    chk("x0_op1", ex_op1, 32'h0);
    chk("x0_op2", ex_op2, 32'h0);
    chk("x0_ex_wr", 32'(ex_wr), 32'd0);
    @(negedge clk);
    #1;
    chk("x0_no_reads", 32'(rd_pulses - snap), 32'd0);
    chk("x0_busy_same", dut.u_sb.busy_q, 32'h00000200);

    // rs2 == x0 with use_rs2, rd == x0 with wr
    dispatch(5'd6, 5'd0, 1'b1, 5'd0, 1'b1);
    wait_ex(20, n);
    chk("rs2x0_lat", 32'(n), 32'd3);
    chk("rs2x0_op1", ex_op1, 32'h000000FF);
    chk("rs2x0_op2", ex_op2, 32'h0);
    @(negedge clk);
    #1;
    chk("rdx0_no_busy", dut.u_sb.busy_q, 32'h00000200);

    // Backpressure
    ex_ready = 1'b0;
    dispatch(5'd6, 5'd5, 1'b1, 5'd10, 1'b1);
    wait_ex(20, n);
    chk("bp_lat", 32'(n), 32'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("bp_valid_held", 32'(ex_valid), 32'd1);
      chk("bp_op1", ex_op1, 32'h000000FF);
      chk("bp_op2", ex_op2, 32'hA5A50001);
      chk("bp_rd", 32'(ex_rd), 32'd10);
      chk("bp_dec_ready", 32'(dec_ready), 32'd0);
      chk("bp_busy10_clear", 32'(dut.u_sb.busy_q[10]), 32'd0);
    end
    @(negedge clk);
    ex_ready = 1'b1;
    #1;
    chk("bp_busy10_before_hs", 32'(dut.u_sb.busy_q[10]), 32'd0);
    @(negedge clk);
    #1;
    chk("bp_busy10_after_hs", dut.u_sb.busy_q, 32'h00000600);
    chk("bp_ex_valid_drop", 32'(ex_valid), 32'd0);

    // Reset while in S_RS2 discards the instruction
    dispatch(5'd5, 5'd6, 1'b1, 5'd11, 1'b1);
    @(negedge clk);
    dec_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_no_read", 32'(rf_read_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_idle", 32'(dec_ready), 32'd1);
    chk("mid_rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("mid_rst_busy", dut.u_sb.busy_q, 32'h0);
    chk("mid_rst_ex_rd", 32'(ex_rd), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("mid_rst_stays_idle", 32'(ex_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-to-execute stage sitting directly upstream of the register file.
- Accepts one decoded instruction at a time and checks a busy-bit scoreboard for RAW/WAW hazards.
- Reads up to two source operands through the register file's single shared index port, which has a registered 1-cycle read; writebacks share the same port and take priority.
- Hands operands to execute over a valid/ready handshake.

Parameters:
XLEN, 32, data width
ADDR_W, 5, register index width (32 registers)

Ports:
clk  in  1  clock
reset  in  1  reset
dec_valid  in  1  decoded instruction valid
dec_ready  out  1  stage can accept instruction
dec_rs1  in  ADDR_W  source 1 index
dec_rs2  in  ADDR_W  source 2 index
dec_use_rs2  in  1  instruction reads rs2
dec_rd  in  ADDR_W  destination index
dec_wr  in  1  instruction writes rd
wb_valid  in  1  writeback request; always accepted
wb_rd  in  ADDR_W  writeback index
wb_data  in  XLEN  writeback data
rf_index  out  ADDR_W  register file index
rf_read_en  out  1  register file read enable
rf_write_en  out  1  register file write enable
rf_wdata  out  XLEN  register file write data
rf_rdata  in  XLEN  register file read data, valid the cycle after rf_read_en
ex_valid  out  1  operands valid
ex_ready  in  1  execute accepts
ex_op1  out  XLEN  operand 1
ex_op2  out  XLEN  operand 2
ex_rd  out  ADDR_W  destination
ex_wr  out  1  destination write flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset state:
  - state S_IDLE; busy[31:0]=0; cap1/cap2 pending=0.
  - ex_valid=0; ex_op1, ex_op2, ex_rd, ex_wr = 0.
  - rf_read_en=0, rf_write_en=0, rf_index=0, rf_wdata=0.
  - Reset mid-operation discards the held instruction. A wb_valid in the reset cycle is ignored.
- Writeback (any state):
  - wb_valid with wb_rd!=0 drives rf_write_en=1, rf_index=wb_rd, rf_wdata=wb_data, and clears busy[wb_rd].
  - wb_rd==0: no write, busy unchanged.
  - Any read scheduled in that cycle is deferred (rf_read_en=0).
- Hazard on register r: r!=0 and busy[r]=1. x0 is never busy, always reads 0, and never uses the port.
- FSM:
  - S_IDLE: dec_ready=1. On dec_valid, latch rs1/rs2/use_rs2/rd/wr and go to S_RS1. dec_ready=0 in all other states.
  - S_RS1: wait while hazard(rs1), or (wr and hazard(rd)) [WAW], or wb_valid. Then:
    - rs1==0: op1=0, go to S_RS2.
    - else: rf_read_en=1, rf_index=rs1, set cap1, go to S_RS2.
  - S_RS2: if cap1, capture rf_rdata into op1 and clear cap1; this capture happens even while waiting. Then:
    - !use_rs2: op2=0, go to S_DONE.
    - else wait while hazard(rs2) or wb_valid.
    - rs2==0: op2=0, go to S_DONE.
    - else: read rs2, set cap2, go to S_DONE.
  - S_DONE: if cap2, capture rf_rdata into op2 and clear cap2. ex_valid = (state==S_DONE && !cap2). On ex_valid&&ex_ready: if wr and rd!=0, set busy[rd]; go to S_IDLE.
- Set/clear priority: a set and a clear of the same busy bit in one cycle leaves it set.
- Backpressure: while ex_valid && !ex_ready, all ex_* outputs hold stable.
- Latency, no stalls, measured from the accept edge:
  - two reads: ex_valid in cycle 4.
  - one read (use_rs2=0): cycle 3.
  - no reads: cycle 3.
- Throughput: one instruction per ≥4 cycles. Pipelining is not required.

Decomposition:
- Package opfetch_pkg: XLEN, ADDR_W, and the state enum (S_IDLE, S_RS1, S_RS2, S_DONE).
- Sub-module reg_scoreboard holds the 32 busy bits, with set port (en, idx), clear port (en, idx), set-wins rule, x0 hardwired 0, and two combinational busy lookups plus a third for rd.

Test Plan:
- Reset -> dec_ready=1, ex_valid=0, rf_read_en=0, rf_write_en=0, all busy=0; repeat reset mid-S_RS2 -> back to S_IDLE, ex_valid=0.
- wb x5=0xA5A50001, x6=0x000000FF; dispatch rs1=5 rs2=6 rd=7 wr=1, ex_ready=1 -> ex_valid in cycle 4, op1=0xA5A50001, op2=0x000000FF, busy[7]=1 after the handshake.
- RAW: next rs1=7 -> no read, held in S_RS1; wb rd=7 data 0x00001234 -> read issues the next cycle, op1=0x00001234.
- Port conflict: wb_valid high for 3 cycles while in S_RS1 -> rf_read_en=0 and rf_write_en=1 for those 3 cycles, then the read issues, and latency grows by exactly 3.
- x0/no-rs2: rs1=0, use_rs2=0, wr=0 -> no rf_read_en pulse, ex_valid in cycle 3, op1=0, op2=0, busy unchanged.
- Backpressure: ex_ready=0 for 5 cycles -> ex_* stable, dec_ready=0, busy[rd] not set until the cycle ex_ready=1.
